// File: rtl/gac_rf_read_arb.sv
// gac_rf_read_arb: round-robin arbiter sharing one register read mux, two-stage registered read pipeline
module gac_rf_read_arb #(
    parameter int NREQ    = 4,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int ZERO_R0 = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]      mux_sel,
    input  logic [DW-1:0]      mux_q,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
    logic [AW-1:0]   addr_a [NREQ];
    logic [IW-1:0]   ptr_q, ptr_d, s1_id_q, s1_id_d, win, idx;
    logic [IW:0]     sum;
    logic            found, grant;
    logic            s1_valid_q, s1_valid_d, s1_zero_q, s1_zero_d;
    logic [AW-1:0]   mux_sel_q, mux_sel_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    genvar i;
    for (i = 0; i < NREQ; i++) begin : g_addr
        assign addr_a[i] = req_addr[i*AW +: AW];
    end
    // search upward from the pointer, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            idx = IW'(sum >= (IW+1)'(NREQ) ? sum - (IW+1)'(NREQ) : sum);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant       = found && !stall && !reset;
        ptr_d       = grant ? (win == IW'(NREQ-1) ? '0 : win + 1'b1) : ptr_q;
        s1_valid_d  = grant;
        mux_sel_d   = grant ? addr_a[win] : mux_sel_q;
        s1_id_d     = grant ? win : s1_id_q;
        s1_zero_d   = grant ? (addr_a[win] == '0 && ZERO_R0 != 0) : s1_zero_q;
        rsp_valid_d = s1_valid_q ? ONE << s1_id_q : '0;
        rsp_data_d  = s1_valid_q ? (s1_zero_q ? '0 : mux_q) : rsp_data_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_zero_q   <= 1'b0;
            mux_sel_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_zero_q   <= s1_zero_d;
            mux_sel_q   <= mux_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
    assign req_ready = grant ? ONE << win : '0;
    assign mux_sel   = mux_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = s1_valid_q | (|rsp_valid_q);
endmodule

// File: tb/tb_gac_rf_read_arb.sv
// tb_gac_rf_read_arb: directed and random traffic checked against a queue-based scoreboard model
module tb_gac_rf_read_arb;
    localparam int N = 4;
    logic          clk = 1'b0, reset = 1'b1, stall = 1'b0, force_ff = 1'b0;
    logic [N-1:0]  rv = '0;
    logic [N*5-1:0] ra = '0;
    logic [N-1:0]  rdy0, rdy1, rspv0, rspv1;
    logic [4:0]    sel0, sel1;
    logic [31:0]   q0, q1, d0, d1;
    logic          busy0, busy1;
    logic [31:0]   mem [32];
    int            n_chk = 0, n_pass = 0, cyc = 0, mptr = 0;
    logic [4:0]    exp_sel = '0;
    logic [31:0]   exp_dz = '0, exp_dn = '0;
    logic [N-1:0]  last_gnt = '0;
    typedef struct { int g; int id; logic [4:0] a; logic [31:0] dz; logic [31:0] dn; } ent_t;
    ent_t sb [$];

    gac_rf_read_arb #(.NREQ(N), .AW(5), .DW(32), .ZERO_R0(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(rv), .req_addr(ra),
        .req_ready(rdy0), .mux_sel(sel0), .mux_q(q0), .rsp_valid(rspv0),
        .rsp_data(d0), .busy(busy0));
    gac_rf_read_arb #(.NREQ(N), .AW(5), .DW(32), .ZERO_R0(0)) dut_nz (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(rv), .req_addr(ra),
        .req_ready(rdy1), .mux_sel(sel1), .mux_q(q1), .rsp_valid(rspv1),
        .rsp_data(d1), .busy(busy1));

    assign q0 = force_ff ? 32'hFFFF_FFFF : mem[sel0];
    assign q1 = force_ff ? 32'hFFFF_FFFF : mem[sel1];
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int r, input logic [4:0] a);
        ra[r*5 +: 5] = a;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // reference model: winner by rotating search, expected responses kept in grant order with due cycles
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            mptr = 0; exp_sel = '0; exp_dz = '0; exp_dn = '0; last_gnt = '0;
        end else begin
            logic [N-1:0] exp_rv, exp_rdy;
            logic         bz;
            int           w;
            logic [4:0]   a;
            logic [31:0]  raw;
            cyc++;
            exp_rv = '0;
            if (sb.size() > 0 && sb[0].g == cyc - 2) begin
                exp_rv = N'(1) << sb[0].id;
                exp_dz = sb[0].dz;
                exp_dn = sb[0].dn;
                void'(sb.pop_front());
            end
            bz = (exp_rv != 0) || (sb.size() > 0 && sb[0].g == cyc - 1);
            chk("mux_sel", 32'(sel0), 32'(exp_sel));
            chk("rsp_valid", 32'(rspv0), 32'(exp_rv));
            chk("rsp_data", d0, exp_dz);
            chk("rsp_data_nz", d1, exp_dn);
            chk("busy", 32'(busy0), 32'(bz));
            w = stall ? -1 : pick(rv, mptr);
            exp_rdy = (w < 0) ? '0 : N'(1) << w;
            chk("req_ready", 32'(rdy0), 32'(exp_rdy));
            last_gnt = exp_rdy;
            if (w >= 0) begin
                a = ra[w*5 +: 5];
                raw = force_ff ? 32'hFFFF_FFFF : mem[a];
                sb.push_back('{cyc, w, a, (a == 0) ? 32'h0 : raw, raw});
                exp_sel = a;
                mptr = (w + 1) % N;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[7] = 32'hDEAD_BEEF;
        #2;
        chk("rst_mux_sel", 32'(sel0), 32'h0);
        chk("rst_rsp_valid", 32'(rspv0), 32'h0);
        chk("rst_rsp_data", d0, 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        rv = '1;
        #1;
        chk("rst_req_ready", 32'(rdy0), 32'h0);
        rv = '0;
        step(); step();
        reset = 1'b0;
        // single read of address 7
        rv = 4'b0001; set_addr(0, 5'd7);
        step();
        rv = '0;
        repeat (3) step();
        // fairness: all requesting, distinct addresses
        set_addr(0, 5'd3); set_addr(1, 5'd9); set_addr(2, 5'd17); set_addr(3, 5'd31);
        rv = '1;
        repeat (8) step();
        // move pointer to 2, then skip idle requesters and wrap
        rv = 4'b0010;
        step();
        rv = 4'b1001;
        repeat (3) step();
        // stall with requests pending
        rv = '1;
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (3) step();
        // stall and request rising together
        rv = '0;
        repeat (3) step();
        stall = 1'b1; rv = 4'b0100;
        step();
        stall = 1'b0;
        step();
        rv = '0;
        repeat (3) step();
        // zero register against forced mux data
        force_ff = 1'b1;
        rv = 4'b0001; set_addr(0, 5'd0);
        step();
        set_addr(0, 5'd31);
        step();
        rv = '0;
        repeat (3) step();
        force_ff = 1'b0;
        // asynchronous reset with both stages occupied
        rv = '1;
        repeat (3) step();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(rspv0), 32'h0);
        chk("arst_mux_sel", 32'(sel0), 32'h0);
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_rsp_data", d0, 32'h0);
        chk("arst_req_ready", 32'(rdy0), 32'h0);
        step();
        reset = 1'b0;
        repeat (3) step();
        // random traffic; ungranted requesters hold their address
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            for (int r = 0; r < N; r++) begin
                if (rv[r] && !last_gnt[r]) begin
                    if ($urandom_range(0, 9) == 0) rv[r] = 1'b0;
                end else begin
                    rv[r] = 1'($urandom_range(0, 1));
                    set_addr(r, ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 5'd31 : 5'd0)
                                                           : 5'($urandom_range(0, 31)));
                end
            end
            step();
        end
        rv = '0; stall = 1'b0;
        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
